// File: rtl/input_conditioner.sv
// Input conditioner for four raw push-button/coin pins. Each channel is synchronized and
// debounced, then a fixed-priority arbiter emits at most one single-cycle press pulse per clock.
module input_conditioner #(
    parameter  int DEBOUNCE_CYCLES = 1_000_000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       coin_10_raw,
    input  logic       coin_25_raw,
    input  logic       next_raw,
    input  logic       select_raw,
    output logic       coin_10_pulse,
    output logic       coin_25_pulse,
    output logic       next_pulse,
    output logic       select_pulse,
    output logic [3:0] level,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel index: 0 = coin_10, 1 = coin_25, 2 = next, 3 = select.
    logic [3:0]             raw_s;
    logic [3:0]             sync1_q;
    logic [3:0]             sync2_q;
    logic [3:0][CNT_W-1:0]  cnt_q;
    logic [3:0][CNT_W-1:0]  cnt_d;
    logic [3:0]             stable_q;
    logic [3:0]             stable_d;
    logic [3:0]             press_s;
    logic [3:0]             pending_q;
    logic [3:0]             pending_d;
    logic [3:0]             grant_s;
    logic [3:0]             pulse_q;
    logic [3:0]             pulse_d;

    assign raw_s = {select_raw, next_raw, coin_25_raw, coin_10_raw};

    // Debounce: the stable level flips only after DEBOUNCE_CYCLES consecutive disagreements.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        press_s = stable_d & ~stable_q;
    end

    // Fixed-priority grant: coin_25 > coin_10 > select > next.
    always_comb begin
        grant_s = 4'b0000;
        if (pending_q[1]) begin
            grant_s = 4'b0010;
        end else if (pending_q[0]) begin
            grant_s = 4'b0001;
        end else if (pending_q[3]) begin
            grant_s = 4'b1000;
        end else if (pending_q[2]) begin
            grant_s = 4'b0100;
        end else begin
            grant_s = 4'b0000;
        end
        // A press landing on another channel's grant edge simply waits in pending.
        pending_d = (pending_q & ~grant_s) | press_s;
        pulse_d   = grant_s;
    end

    // State registers: synchronizers, debounce counters, levels, pending flags and pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 4'b0000;
            sync2_q   <= 4'b0000;
            cnt_q     <= '0;
            stable_q  <= 4'b0000;
            pending_q <= 4'b0000;
            pulse_q   <= 4'b0000;
        end else begin
            sync1_q   <= raw_s;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            pending_q <= pending_d;
            pulse_q   <= pulse_d;
        end
    end

    assign coin_10_pulse = pulse_q[0];
    assign coin_25_pulse = pulse_q[1];
    assign next_pulse    = pulse_q[2];
    assign select_pulse  = pulse_q[3];
    assign level         = stable_q;
    assign busy          = |pending_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a window-based reference model predicts levels,
// busy and the cycle/channel of every press pulse; a negedge monitor compares against the DUT.
module tb_input_conditioner;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] raw = 4'b0000;
    logic       coin_10_pulse, coin_25_pulse, next_pulse, select_pulse, busy;
    logic [3:0] level;

    input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .coin_10_raw   (raw[0]),
        .coin_25_raw   (raw[1]),
        .next_raw      (raw[2]),
        .select_raw    (raw[3]),
        .coin_10_pulse (coin_10_pulse),
        .coin_25_pulse (coin_25_pulse),
        .next_pulse    (next_pulse),
        .select_pulse  (select_pulse),
        .level         (level),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int ch;} exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulse_cnt[4] = '{0, 0, 0, 0};
    int last_pulse[4] = '{-1, -1, -1, -1};

    // Reference model state: two-stage delay line, window of past sync2 samples, set of pending presses.
    bit [3:0] m_s1, m_s2, m_stable, m_pend;
    bit [3:0] hist[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_s1 = 4'b0; m_s2 = 4'b0; m_stable = 4'b0; m_pend = 4'b0;
        hist.delete();
    endtask

    task automatic model_edge(input bit [3:0] r);
        int order[4] = '{1, 0, 3, 2};
        int g;
        bit flip;
        bit [3:0] rose;
        if (!reset_n) begin
            model_clear();
            return;
        end
        g = -1;
        for (int k = 0; k < 4; k++)
            if (g < 0 && m_pend[order[k]]) g = order[k];
        hist.push_back(m_s2);
        if (hist.size() > D) void'(hist.pop_front());
        rose = 4'b0;
        for (int ch = 0; ch < 4; ch++) begin
            flip = (hist.size() == D);
            foreach (hist[k]) if (hist[k][ch] == m_stable[ch]) flip = 1'b0;
            if (flip) begin
                m_stable[ch] = ~m_stable[ch];
                if (m_stable[ch]) rose[ch] = 1'b1;
            end
        end
        m_s2 = m_s1;
        m_s1 = r;
        if (g >= 0) begin
            m_pend[g] = 1'b0;
            sb.push_back('{cyc: cyc, ch: g});
        end
        m_pend = m_pend | rose;
    endtask

    task automatic step(input bit [3:0] r, input logic rn);
        @(negedge clk);
        raw = r;
        reset_n = rn;
        @(posedge clk);
        cyc++;
        model_edge(r);
    endtask

    task automatic run(input bit [3:0] r, input int n);
        for (int k = 0; k < n; k++) step(r, 1'b1);
    endtask

    // Monitor: compares every cycle away from the active edge and drains the scoreboard.
    always @(negedge clk) begin
        logic [3:0] p;
        int ch;
        exp_t e;
        p = {select_pulse, next_pulse, coin_25_pulse, coin_10_pulse};
        chk("onehot0", int'($onehot0(p)), 1);
        chk("level", int'(level), int'(m_stable));
        chk("busy", int'(busy), int'(|m_pend));
        if (p != 4'b0) begin
            ch = 0;
            for (int k = 3; k >= 0; k--) if (p[k]) ch = k;
            pulse_cnt[ch]++;
            last_pulse[ch] = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_pulse", ch, -1);
            end else begin
                e = sb.pop_front();
                chk("pulse_ch", ch, e.ch);
                chk("pulse_cyc", cyc, e.cyc);
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("missed_pulse", -1, e.ch);
        end
    end

    initial begin
        int c0, base, rel;
        bit [3:0] cur;
        int hold[4];
        model_clear();

        // Reset state
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b0);
        chk("reset_pulses", int'({select_pulse, next_pulse, coin_25_pulse, coin_10_pulse}), 0);
        chk("reset_level", int'(level), 0);
        run(4'b0000, 4);

        // 1. Clean press on coin_10
        c0 = cyc; base = pulse_cnt[0];
        run(4'b0001, 50);
        chk("clean_count", pulse_cnt[0] - base, 1);
        chk("clean_cycle", last_pulse[0], c0 + 11);
        run(4'b0000, 20);

        // 2. Bounce on next
        base = pulse_cnt[2];
        for (int k = 0; k < 30; k++) step(((k / 3) % 2 == 0) ? 4'b0100 : 4'b0000, 1'b1);
        chk("bounce_quiet", pulse_cnt[2] - base, 0);
        run(4'b0100, 20);
        chk("bounce_count", pulse_cnt[2] - base, 1);
        run(4'b0000, 20);

        // 3. Simultaneous press on all channels
        c0 = cyc;
        run(4'b1111, 20);
        chk("simul_coin25", last_pulse[1], c0 + 11);
        chk("simul_coin10", last_pulse[0], c0 + 12);
        chk("simul_select", last_pulse[3], c0 + 13);
        chk("simul_next", last_pulse[2], c0 + 14);
        run(4'b0000, 20);

        // 4. Glitch on coin_25 shorter than the debounce window
        base = pulse_cnt[1];
        run(4'b0010, 7);
        run(4'b0000, 20);
        chk("glitch_count", pulse_cnt[1] - base, 0);
        chk("glitch_level", int'(level[1]), 0);

        // 5. Asynchronous reset mid-press on select
        base = pulse_cnt[3];
        run(4'b1000, 6);
        #2;
        reset_n = 1'b0;
        model_clear();
        sb.delete();
        #1;
        chk("async_rst_out", int'({select_pulse, next_pulse, coin_25_pulse, coin_10_pulse, level, busy}), 0);
        for (int k = 0; k < 3; k++) step(4'b1000, 1'b0);
        rel = cyc;
        run(4'b1000, 20);
        chk("rst_count", pulse_cnt[3] - base, 1);
        chk("rst_cycle", last_pulse[3], rel + 11);
        run(4'b0000, 20);

        // 6. Re-press: short low is filtered, long low re-arms
        base = pulse_cnt[3];
        run(4'b1000, 20); run(4'b0000, 4); run(4'b1000, 20); run(4'b0000, 20);
        chk("repress_short", pulse_cnt[3] - base, 1);
        base = pulse_cnt[3];
        run(4'b1000, 20); run(4'b0000, 12); run(4'b1000, 20); run(4'b0000, 20);
        chk("repress_long", pulse_cnt[3] - base, 2);

        // Randomized per-channel hold lengths
        cur = 4'b0000;
        hold = '{0, 0, 0, 0};
        for (int k = 0; k < 3000; k++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (hold[ch] == 0) begin
                    cur[ch] = 1'($urandom_range(0, 1));
                    hold[ch] = $urandom_range(1, 24);
                end
                hold[ch]--;
            end
            step(cur, 1'b1);
        end
        run(4'b0000, 30);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
